// File: rtl/jpeg_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_dec_pkg
// Description : Shared types and constants for the JPEG coefficient unpacker
// Revision    : 1.0  initial release
// ============================================================================
package jpeg_dec_pkg;

    localparam int COEF_W_DEFAULT = 12;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } unpack_state_t;

    // Zigzag scan position -> natural (raster) index within an 8x8 block.
    localparam logic [5:0] ZIGZAG_TO_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage
`default_nettype wire

// File: rtl/jpeg_amp_decode.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_amp_decode
// Description : Combinational JPEG amplitude extension (size/bits -> signed)
// Revision    : 1.0  initial release
// ============================================================================
module jpeg_amp_decode (
    input  logic [3:0]         size,
    input  logic [15:0]        amp,
    output logic signed [16:0] value
);

    logic [16:0] lim;
    logic [16:0] bits;

    always_comb begin
        lim   = (17'd1 << size) - 17'd1;
        bits  = {1'b0, amp} & lim;
        value = '0;
        if (size != 4'd0) begin
            // A clear top bit encodes a negative value offset by 2^size - 1.
            if (amp[size - 4'd1]) begin
                value = $signed(bits);
            end else begin
                value = $signed(bits - lim);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jpeg_coef_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_coef_unpacker
// Description : Collects DC/AC run-size symbols into an 8x8 coefficient block
//               and drains it in natural order. Optional macro
//               JPEG_COEF_SAT_EN saturates the DC prediction sum.
// Revision    : 1.0  initial release
// ============================================================================
module jpeg_coef_unpacker
    import jpeg_dec_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic              sym_dc,
    input  logic [3:0]        sym_run,
    input  logic [3:0]        sym_size,
    input  logic [15:0]       sym_amp,
    input  logic              blk_restart,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data,
    output logic [5:0]        coef_index,
    output logic              coef_last,
    output logic              err
);

    localparam int SUM_W = ((COEF_W > 17) ? COEF_W : 17) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};

    unpack_state_t     state, state_nxt;
    logic [6:0]        k, k_nxt;
    logic [COEF_W-1:0] pred, pred_nxt;
    logic [5:0]        drain_idx, drain_idx_nxt;
    logic              err_nxt;
    logic [63:0]       mask;
    logic [COEF_W-1:0] coef_buf [64];

    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              clr_mask;

    logic signed [16:0]      amp_value;
    logic signed [SUM_W-1:0] diff_ext;
    logic [COEF_W-1:0]       pred_eff;
    logic [COEF_W-1:0]       dc_val;
    logic [COEF_W-1:0]       ac_val;
    logic [6:0]              ac_target;
    logic [6:0]              zrl_target;

    jpeg_amp_decode u_amp_decode (
        .size  (sym_size),
        .amp   (sym_amp),
        .value (amp_value)
    );

    assign pred_eff   = blk_restart ? '0 : pred;
    assign diff_ext   = {{(SUM_W-17){amp_value[16]}}, amp_value};
    assign ac_target  = k + {3'b000, sym_run};
    assign zrl_target = k + 7'd16;

    // AC amplitudes wider than a coefficient are clamped rather than wrapped.
    always_comb begin
        if (diff_ext > SAT_MAX) begin
            ac_val = SAT_MAX[COEF_W-1:0];
        end else if (diff_ext < SAT_MIN) begin
            ac_val = SAT_MIN[COEF_W-1:0];
        end else begin
            ac_val = diff_ext[COEF_W-1:0];
        end
    end

`ifdef JPEG_COEF_SAT_EN
    logic signed [SUM_W-1:0] pred_ext;
    logic signed [SUM_W-1:0] dc_sum;

    assign pred_ext = {{(SUM_W-COEF_W){pred_eff[COEF_W-1]}}, pred_eff};
    assign dc_sum   = pred_ext + diff_ext;

    always_comb begin
        if (dc_sum > SAT_MAX) begin
            dc_val = SAT_MAX[COEF_W-1:0];
        end else if (dc_sum < SAT_MIN) begin
            dc_val = SAT_MIN[COEF_W-1:0];
        end else begin
            dc_val = dc_sum[COEF_W-1:0];
        end
    end
`else
    assign dc_val = pred_eff + diff_ext[COEF_W-1:0];
`endif

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        pred_nxt      = pred_eff;
        drain_idx_nxt = drain_idx;
        err_nxt       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        clr_mask      = 1'b0;
        sym_ready     = (state == ST_FILL);
        coef_valid    = (state == ST_DRAIN);

        case (state)
            ST_FILL: begin
                if (sym_valid) begin
                    if (sym_dc) begin
                        if (k != 7'd0) begin
                            err_nxt = 1'b1;
                        end else begin
                            wr_en    = 1'b1;
                            wr_addr  = 6'd0;
                            wr_data  = dc_val;
                            pred_nxt = dc_val;
                            k_nxt    = 7'd1;
                        end
                    end else if (k == 7'd0) begin
                        err_nxt = 1'b1;
                    end else if (sym_size == 4'd0) begin
                        if (sym_run == 4'd0) begin
                            state_nxt = ST_DRAIN;
                        end else if (sym_run == 4'd15) begin
                            // A ZRL landing past the block is treated as an overrun.
                            if (zrl_target >= 7'd64) begin
                                err_nxt   = (zrl_target > 7'd64);
                                state_nxt = ST_DRAIN;
                            end else begin
                                k_nxt = zrl_target;
                            end
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (ac_target > 7'd63) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DRAIN;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = ZIGZAG_TO_NAT[ac_target[5:0]];
                        wr_data = ac_val;
                        k_nxt   = ac_target + 7'd1;
                        if (ac_target == 7'd63) begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (coef_ready) begin
                    if (drain_idx == 6'd63) begin
                        drain_idx_nxt = 6'd0;
                        k_nxt         = 7'd0;
                        clr_mask      = 1'b1;
                        state_nxt     = ST_FILL;
                    end else begin
                        drain_idx_nxt = drain_idx + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_FILL;
            k         <= '0;
            pred      <= '0;
            drain_idx <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            pred      <= pred_nxt;
            drain_idx <= drain_idx_nxt;
            err       <= err_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (clr_mask) begin
            mask <= '0;
        end else if (wr_en) begin
            mask[wr_addr] <= 1'b1;
        end
    end

    // Buffer contents are only trusted where the mask bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            coef_buf[wr_addr] <= wr_data;
        end
    end

    assign coef_index = drain_idx;
    assign coef_last  = (state == ST_DRAIN) && (drain_idx == 6'd63);
    assign coef_data  = ((state == ST_DRAIN) && mask[drain_idx]) ? coef_buf[drain_idx] : '0;

endmodule
`default_nettype wire
